// File: rtl/run_ctrl_pkg.sv
// Shared encodings for the run-control unit: run modes and FSM states.
package run_ctrl_pkg;

    localparam logic [1:0] MODE_FREE   = 2'd0;
    localparam logic [1:0] MODE_RUN_BP = 2'd1;
    localparam logic [1:0] MODE_STEP   = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StStepWait,
        StStepGo,
        StHalt
    } state_e;

    // Mode 3 is reserved and behaves like free-run.
    function automatic state_e launch_state(input logic [1:0] mode);
        return (mode == MODE_STEP) ? StStepWait : StRun;
    endfunction

endpackage

// File: rtl/run_ctrl_pb_edge_sync.sv
// Step pushbutton synchronizer: two metastability flops plus one history flop
// for rising-edge detection.
module pb_edge_sync (
    input  logic Clk,
    input  logic reset,
    input  logic pb,
    output logic rise
);

    logic [2:0] sync_q;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], pb};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/run_ctrl.sv
// Run-control unit: gates the core clock enable and halts on breakpoint,
// cycle budget or manual stop; supports free-run, run-to-breakpoint and single-step.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned NUM_BP    = 4,
    parameter int unsigned CNT_WIDTH = 16,
    localparam int unsigned IDX_W    = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic                       Clk,
    input  logic                       reset,
    input  logic [1:0]                 mode,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       pb,
    input  logic [PC_WIDTH-1:0]        pc,
    input  logic [NUM_BP*PC_WIDTH-1:0] bp_addr,
    input  logic [NUM_BP-1:0]          bp_en,
    input  logic [CNT_WIDTH-1:0]       cycle_limit,
    output logic                       cpu_en,
    output logic                       halted,
    output logic                       bp_hit,
    output logic [IDX_W-1:0]           hit_idx,
    output logic                       timeout,
    output logic [CNT_WIDTH-1:0]       cycle_count
);

    state_e           state_q;
    logic [1:0]       mode_q;
    logic             skip_q;
    logic             pb_rise;
    logic [NUM_BP-1:0] match;
    logic [IDX_W-1:0] match_idx;
    logic             bp_stop;
    logic             budget_hit;
    logic             start_ok;

    pb_edge_sync u_pb_sync (
        .Clk   (Clk),
        .reset (reset),
        .pb    (pb),
        .rise  (pb_rise)
    );

    for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_bp_cmp
        assign match[gi] = bp_en[gi] && (pc == bp_addr[gi*PC_WIDTH +: PC_WIDTH]);
    end

    // Scan downwards so the lowest matching index wins.
    always_comb begin
        match_idx = '0;
        for (int i = int'(NUM_BP) - 1; i >= 0; i--) begin
            if (match[i]) begin
                match_idx = IDX_W'(i);
            end
        end
    end

    assign bp_stop    = (mode_q == MODE_RUN_BP) && !skip_q && (|match);
    assign budget_hit = (cycle_limit != '0) && (cycle_count == cycle_limit);
    assign start_ok   = start && !stop;

    always_comb begin
        cpu_en = 1'b0;
        unique case (state_q)
            StRun:    cpu_en = !(bp_stop || budget_hit || stop);
            StStepGo: cpu_en = !(budget_hit || stop);
            default:  cpu_en = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            mode_q      <= MODE_FREE;
            skip_q      <= 1'b0;
            halted      <= 1'b0;
            bp_hit      <= 1'b0;
            hit_idx     <= '0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            if (cpu_en && (cycle_count != '1)) begin
                cycle_count <= cycle_count + 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    skip_q <= 1'b0;
                    if (start_ok) begin
                        mode_q      <= mode;
                        cycle_count <= '0;
                        bp_hit      <= 1'b0;
                        timeout     <= 1'b0;
                        hit_idx     <= '0;
                        state_q     <= launch_state(mode);
                    end
                end
                StRun: begin
                    skip_q <= 1'b0;
                    if (bp_stop || budget_hit || stop) begin
                        state_q <= StHalt;
                        halted  <= 1'b1;
                        bp_hit  <= bp_stop;
                        timeout <= budget_hit;
                        if (bp_stop) begin
                            hit_idx <= match_idx;
                        end
                    end
                end
                StStepWait: begin
                    if (stop || budget_hit) begin
                        state_q <= StHalt;
                        halted  <= 1'b1;
                        timeout <= budget_hit;
                    end else if (pb_rise) begin
                        state_q <= StStepGo;
                    end
                end
                StStepGo: begin
                    if (stop || budget_hit) begin
                        state_q <= StHalt;
                        halted  <= 1'b1;
                        timeout <= budget_hit;
                    end else begin
                        state_q <= StStepWait;
                    end
                end
                StHalt: begin
                    if (start_ok) begin
                        mode_q      <= mode;
                        cycle_count <= '0;
                        bp_hit      <= 1'b0;
                        timeout     <= 1'b0;
                        hit_idx     <= '0;
                        halted      <= 1'b0;
                        // Let the core step off the breakpoint it stopped on.
                        skip_q      <= 1'b1;
                        state_q     <= launch_state(mode);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl with a simple core model (pc += 4 per enabled cycle).
module tb_run_ctrl;
    import run_ctrl_pkg::*;

    localparam int unsigned PC_WIDTH  = 32;
    localparam int unsigned NUM_BP    = 4;
    localparam int unsigned CNT_WIDTH = 10;

    logic                 Clk;
    logic                 reset;
    logic [1:0]           mode;
    logic                 start;
    logic                 stop;
    logic                 pb;
    logic [31:0]          pc;
    logic [3:0][31:0]     bp_addr;
    logic [3:0]           bp_en;
    logic [9:0]           cycle_limit;
    logic                 cpu_en;
    logic                 halted;
    logic                 bp_hit;
    logic [1:0]           hit_idx;
    logic                 timeout;
    logic [9:0]           cycle_count;

    int n_checks = 0;
    int n_fail   = 0;
    int en_cycles = 0;

    run_ctrl #(
        .PC_WIDTH  (PC_WIDTH),
        .NUM_BP    (NUM_BP),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .Clk         (Clk),
        .reset       (reset),
        .mode        (mode),
        .start       (start),
        .stop        (stop),
        .pb          (pb),
        .pc          (pc),
        .bp_addr     (bp_addr),
        .bp_en       (bp_en),
        .cycle_limit (cycle_limit),
        .cpu_en      (cpu_en),
        .halted      (halted),
        .bp_hit      (bp_hit),
        .hit_idx     (hit_idx),
        .timeout     (timeout),
        .cycle_count (cycle_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) pc <= 32'd0;
        else if (cpu_en) pc <= pc + 32'd4;
    end

    always @(negedge Clk) begin
        if (reset && cpu_en) en_cycles++;
    end

    typedef struct {
        logic [1:0]       mode;
        logic [9:0]       limit;
        logic [3:0]       en;
        logic [3:0][31:0] bpa;
        logic [31:0]      pc;
        logic             hit;
        logic [1:0]       idx;
        logic             to;
        logic [9:0]       cnt;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        pb    = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_halt(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (halted) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic step_press(input int hold);
        pb = 1'b1;
        repeat (hold) tick();
        pb = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        int base;
        mode        = MODE_FREE;
        bp_addr     = '0;
        bp_en       = '0;
        cycle_limit = '0;
        do_reset();

        check("reset_cpu_en", 32'(cpu_en), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_flags", {29'd0, bp_hit, timeout, 1'b0}, 32'd0);
        check("reset_idx", 32'(hit_idx), 32'd0);
        check("reset_count", 32'(cycle_count), 32'd0);

        // start and stop together in IDLE: stop wins, nothing launches
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) tick();
        check("idle_start_stop_cpu_en", 32'(cpu_en), 32'd0);
        check("idle_start_stop_pc", pc, 32'd0);

        vecs[0] = '{MODE_RUN_BP, 10'd1000, 4'b0001, {32'h0, 32'h0, 32'h0, 32'h58},
                    32'h58, 1'b1, 2'd0, 1'b0, 10'd22};
        vecs[1] = '{MODE_RUN_BP, 10'd0, 4'b1010, {32'h10, 32'h0, 32'h10, 32'h0},
                    32'h10, 1'b1, 2'd1, 1'b0, 10'd4};
        vecs[2] = '{MODE_FREE, 10'd5, 4'b0001, {32'h0, 32'h0, 32'h0, 32'h0},
                    32'h14, 1'b0, 2'd0, 1'b1, 10'd5};
        vecs[3] = '{MODE_RUN_BP, 10'd5, 4'b0100, {32'h0, 32'h14, 32'h0, 32'h0},
                    32'h14, 1'b1, 2'd2, 1'b1, 10'd5};
        vecs[4] = '{2'd3, 10'd3, 4'b0001, {32'h0, 32'h0, 32'h0, 32'h8},
                    32'h0C, 1'b0, 2'd0, 1'b1, 10'd3};
        vecs[5] = '{MODE_RUN_BP, 10'd0, 4'b1000, {32'h30, 32'h0, 32'h0, 32'h20},
                    32'h30, 1'b1, 2'd3, 1'b0, 10'd12};
        vecs[6] = '{MODE_RUN_BP, 10'd0, 4'b0001, {32'h0, 32'h0, 32'h0, 32'h0},
                    32'h0, 1'b1, 2'd0, 1'b0, 10'd0};

        foreach (vecs[i]) begin
            do_reset();
            mode        = vecs[i].mode;
            cycle_limit = vecs[i].limit;
            bp_en       = vecs[i].en;
            bp_addr     = vecs[i].bpa;
            base        = en_cycles;
            pulse_start();
            wait_halt($sformatf("v%0d_halt", i), 2000);
            check($sformatf("v%0d_pc", i), pc, vecs[i].pc);
            check($sformatf("v%0d_bp_hit", i), 32'(bp_hit), 32'(vecs[i].hit));
            check($sformatf("v%0d_hit_idx", i), 32'(hit_idx), 32'(vecs[i].idx));
            check($sformatf("v%0d_timeout", i), 32'(timeout), 32'(vecs[i].to));
            check($sformatf("v%0d_count", i), 32'(cycle_count), 32'(vecs[i].cnt));
            check($sformatf("v%0d_en_cycles", i), 32'(en_cycles - base), 32'(vecs[i].cnt));
            check($sformatf("v%0d_cpu_en_off", i), 32'(cpu_en), 32'd0);
        end

        // Breakpoint halt, then stop / start+stop in HALT, then skip-resume
        do_reset();
        mode        = MODE_RUN_BP;
        cycle_limit = 10'd0;
        bp_en       = 4'b1010;
        bp_addr     = {32'h10, 32'h0, 32'h10, 32'h0};
        pulse_start();
        wait_halt("resume_first_halt", 200);
        check("resume_first_idx", 32'(hit_idx), 32'd1);
        stop = 1'b1;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) tick();
        check("halt_start_stop_halted", 32'(halted), 32'd1);
        check("halt_start_stop_bp_hit", 32'(bp_hit), 32'd1);
        check("halt_start_stop_pc", pc, 32'h10);
        cycle_limit = 10'd3;
        pulse_start();
        check("resume_left_halt", 32'(halted), 32'd0);
        wait_halt("resume_second_halt", 200);
        check("resume_pc", pc, 32'h1C);
        check("resume_timeout", 32'(timeout), 32'd1);
        check("resume_bp_hit", 32'(bp_hit), 32'd0);
        check("resume_count", 32'(cycle_count), 32'd3);

        // Single-step: three presses, one held long
        do_reset();
        mode        = MODE_STEP;
        cycle_limit = 10'd0;
        bp_en       = 4'b1111;
        bp_addr     = {32'h4, 32'h4, 32'h4, 32'h4};
        base        = en_cycles;
        pulse_start();
        repeat (3) tick();
        check("step_idle_cpu_en", 32'(cpu_en), 32'd0);
        step_press(2);
        step_press(20);
        step_press(2);
        repeat (4) tick();
        check("step_en_cycles", 32'(en_cycles - base), 32'd3);
        check("step_pc", pc, 32'h0C);
        check("step_count", 32'(cycle_count), 32'd3);
        check("step_not_halted", 32'(halted), 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        check("step_stop_halted", 32'(halted), 32'd1);
        check("step_stop_flags", {30'd0, bp_hit, timeout}, 32'd0);

        // Budget reached while waiting for a step
        do_reset();
        mode        = MODE_STEP;
        cycle_limit = 10'd2;
        pulse_start();
        step_press(2);
        step_press(2);
        wait_halt("step_budget_halt", 20);
        check("step_budget_timeout", 32'(timeout), 32'd1);
        check("step_budget_pc", pc, 32'h08);
        check("step_budget_count", 32'(cycle_count), 32'd2);

        // Manual stop during free run
        do_reset();
        mode        = MODE_FREE;
        cycle_limit = 10'd0;
        bp_en       = 4'b0000;
        pulse_start();
        repeat (10) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        check("stop_halted", 32'(halted), 32'd1);
        check("stop_flags", {30'd0, bp_hit, timeout}, 32'd0);
        check("stop_count_vs_pc", 32'(cycle_count), pc >> 2);
        check("stop_cpu_en", 32'(cpu_en), 32'd0);

        // Counter saturation with unlimited budget
        do_reset();
        mode        = MODE_FREE;
        cycle_limit = 10'd0;
        pulse_start();
        repeat (1100) tick();
        check("sat_count", 32'(cycle_count), 32'd1023);
        check("sat_still_running", 32'(cpu_en), 32'd1);

        // Asynchronous reset between clock edges
        do_reset();
        mode = MODE_FREE;
        pulse_start();
        repeat (5) tick();
        check("mid_reset_pre_cpu_en", 32'(cpu_en), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_reset_cpu_en", 32'(cpu_en), 32'd0);
        check("mid_reset_count", 32'(cycle_count), 32'd0);
        check("mid_reset_flags", {29'd0, halted, bp_hit, timeout}, 32'd0);
        tick();
        reset = 1'b1;
        repeat (3) tick();
        check("post_reset_idle", 32'(cpu_en), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
